shreg_tx: RTL and testbench

//  Serial transmitter for 74HC595-style shift-register peripherals (R-2R DAC, SAR-ADC DAC word).

---
 rtl/shreg_tx.sv | 159 +++++++++++++++
 tb/tb_shreg_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shreg_tx.sv
// shreg_tx: MSB-first serial transmitter for 74HC595-style chains (sclk shifts, lclk latches).
// Define SHREG_TX_BUFFER_EN to add a one-entry holding register for gapless back-to-back frames.
module shreg_tx #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ser_o,
  output logic             sclk_o,
  output logic             lclk_o
);
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StLatchHi, StLatchLo} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             ser_q, ser_d, sclk_q, sclk_d, lclk_q, lclk_d, done_q, done_d;
  logic             accept, div_last, start;
  logic [WIDTH-1:0] start_word;

`ifdef SHREG_TX_BUFFER_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             launch_ok;
  assign ready_o = ~hold_vld_q;
`else
  assign ready_o = (state_q == StIdle);
`endif

  assign accept   = valid_i & ready_o;
  assign div_last = (div_q == DivLast);
  assign busy_o   = (state_q != StIdle);
  assign done_o   = done_q;
  assign ser_o    = ser_q;
  assign sclk_o   = sclk_q;
  assign lclk_o   = lclk_q;

  // A held word launches from IDLE or straight out of LATCH_LO's final cycle.
  always_comb begin
`ifdef SHREG_TX_BUFFER_EN
    launch_ok  = (state_q == StIdle) || ((state_q == StLatchLo) && div_last);
    start      = launch_ok & (hold_vld_q | accept);
    start_word = hold_vld_q ? hold_q : data_i;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (start && hold_vld_q) begin
      hold_vld_d = 1'b0;
    end else if (accept && !start) begin
      hold_d     = data_i;
      hold_vld_d = 1'b1;
    end
`else
    start      = accept;
    start_word = data_i;
`endif
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q != StIdle) begin
      div_d = div_last ? '0 : div_q + DivW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShiftLo;
          shreg_d = start_word;
          bit_d   = '0;
          div_d   = '0;
        end
      end
      StShiftLo: if (div_last) state_d = StShiftHi;
      StShiftHi: begin
        if (div_last) begin
          shreg_d = shreg_q << 1;
          if (bit_q == BitLast) begin
            state_d = StLatchHi;
          end else begin
            bit_d   = bit_q + BitW'(1);
            state_d = StShiftLo;
          end
        end
      end
      StLatchHi: if (div_last) state_d = StLatchLo;
      StLatchLo: begin
        if (div_last) begin
          state_d = StIdle;
          if (start) begin
            state_d = StShiftLo;
            shreg_d = start_word;
            bit_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pins are registered from the next state so they switch cleanly on clock edges.
    sclk_d = (state_d == StShiftHi);
    lclk_d = (state_d == StLatchHi);
    done_d = (state_d == StLatchLo) && (div_d == DivLast);
    ser_d  = ser_q;
    if (state_d == StIdle) begin
      ser_d = 1'b0;
    end else if ((state_d == StShiftLo) && (state_q != StShiftLo)) begin
      ser_d = shreg_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ser_q   <= 1'b0;
      sclk_q  <= 1'b0;
      lclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ser_q   <= ser_d;
      sclk_q  <= sclk_d;
      lclk_q  <= lclk_d;
      done_q  <= done_d;
    end
  end

`ifdef SHREG_TX_BUFFER_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

endmodule

// File: tb/tb_shreg_tx.sv
// Bench for shreg_tx: two instances (16/2 and 8/3) driving behavioural 74HC595 peripheral models.
module tb_shreg_tx;
  localparam int unsigned WA = 16, DA = 2, WB = 8, DB = 3;
  localparam int unsigned FrameA = 2 * DA * (WA + 1);
  localparam int unsigned FrameB = 2 * DB * (WB + 1);
`ifdef SHREG_TX_BUFFER_EN
  localparam int unsigned GapA = FrameA;
`else
  localparam int unsigned GapA = FrameA + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [WA-1:0] data_a;
  logic [WB-1:0] data_b;
  logic valid_a, ready_a, busy_a, done_a, ser_a, sclk_a, lclk_a;
  logic valid_b, ready_b, busy_b, done_b, ser_b, sclk_b, lclk_b;

  shreg_tx #(.WIDTH(WA), .CLK_DIV(DA)) u_dut_a (
    .clk_i(clk), .reset_i(rst), .data_i(data_a), .valid_i(valid_a), .ready_o(ready_a),
    .busy_o(busy_a), .done_o(done_a), .ser_o(ser_a), .sclk_o(sclk_a), .lclk_o(lclk_a)
  );
  shreg_tx #(.WIDTH(WB), .CLK_DIV(DB)) u_dut_b (
    .clk_i(clk), .reset_i(rst), .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b),
    .busy_o(busy_b), .done_o(done_b), .ser_o(ser_b), .sclk_o(sclk_b), .lclk_o(lclk_b)
  );

  int n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  // Peripheral models: shift on sclk rise, copy to output on lclk rise.
  logic [WA-1:0] sr_a = '0, out_a = '0;
  logic [WB-1:0] sr_b = '0, out_b = '0;
  int lclk_cnt_a = 0, lclk_cnt_b = 0;
  logic [WA-1:0] lat_a[$];
  int unsigned lclk_cyc_a[$];
  always @(posedge sclk_a) sr_a <= {sr_a[WA-2:0], ser_a};
  always @(posedge sclk_b) sr_b <= {sr_b[WB-2:0], ser_b};
  always @(posedge lclk_a) begin
    out_a <= sr_a;
    lat_a.push_back(sr_a);
    lclk_cyc_a.push_back(cyc);
    lclk_cnt_a++;
  end
  always @(posedge lclk_b) begin
    out_b <= sr_b;
    lclk_cnt_b++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? ready_b : ready_a;
  endfunction
  function automatic logic bsy(input bit s);
    return s ? busy_b : busy_a;
  endfunction
  function automatic logic dn(input bit s);
    return s ? done_b : done_a;
  endfunction

  // Sclk phase lengths and ser stability on the 8/3 instance.
  int hi_run_b = 0, lo_run_b = 0;
  logic ser_hold_b = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst || !busy_b) begin
      hi_run_b = 0;
      lo_run_b = 0;
    end else if (sclk_b) begin
      if (hi_run_b == 0) begin
        check_eq("b_sclk_lo_len", lo_run_b, DB);
        ser_hold_b = ser_b;
      end else begin
        check_eq("b_ser_stable", ser_b, ser_hold_b);
      end
      hi_run_b++;
      lo_run_b = 0;
    end else begin
      if (hi_run_b != 0) check_eq("b_sclk_hi_len", hi_run_b, DB);
      hi_run_b = 0;
      lo_run_b++;
    end
  end

  int rl_run = 0, rl_max = 0;
  always @(posedge clk) begin
    #1;
    if (!ready_a) begin
      rl_run++;
      if (rl_run > rl_max) rl_max = rl_run;
    end else begin
      rl_run = 0;
    end
  end

  // Present a word and return just after the edge that accepts it.
  task automatic wait_accept(input bit s, input logic [WA-1:0] w, input bit hold,
                             output bit ok);
    @(negedge clk);
    if (s) begin data_b = w[WB-1:0]; valid_b = 1'b1; end
    else begin data_a = w; valid_a = 1'b1; end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rdy(s)) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    if (!hold) begin
      if (s) valid_b = 1'b0;
      else valid_a = 1'b0;
    end
    if (!ok) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input bit s);
    bit idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(posedge clk);
      #1;
      if (!bsy(s)) idle = 1'b1;
    end
    if (!idle) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic wait_lclk_a(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (lclk_cnt_a >= target) hit = 1'b1;
    end
    if (!hit) check_eq("lclk_timeout", lclk_cnt_a, target);
  endtask

  // One frame with timing: done in the last frame cycle, idle after Frame edges.
  task automatic run_frame(input bit s, input logic [WA-1:0] w);
    int unsigned frame;
    int end_n, done_n, done_cnt, lc0;
    logic [WA-1:0] exp_w;
    bit ok;
    frame = s ? FrameB : FrameA;
    exp_w = s ? (w & 16'h00FF) : w;
    lc0 = s ? lclk_cnt_b : lclk_cnt_a;
    end_n = -1;
    done_n = -1;
    done_cnt = 0;
    wait_accept(s, w, 1'b0, ok);
    if (!ok) return;
    check_eq("busy_after_accept", bsy(s), 1);
`ifdef SHREG_TX_BUFFER_EN
    check_eq("ready_during_frame", rdy(s), 1);
`else
    check_eq("ready_during_frame", rdy(s), 0);
`endif
    for (int n = 1; n <= int'(frame) + 8 && end_n < 0; n++) begin
      @(posedge clk);
      #1;
      if (dn(s)) begin
        done_cnt++;
        done_n = n;
      end
      if (!bsy(s)) end_n = n;
    end
    check_eq("frame_len", end_n, frame);
    check_eq("done_cycle", done_n, frame - 1);
    check_eq("done_pulses", done_cnt, 1);
    check_eq("ready_at_end", rdy(s), 1);
    check_eq("lclk_count", s ? lclk_cnt_b : lclk_cnt_a, lc0 + 1);
    check_eq("latched_word", s ? {8'h00, out_b} : out_a, exp_w);
  endtask

  initial begin
    bit ok;
    int lc0;
    logic [WA-1:0] prev;
    logic [WA-1:0] w;
    logic [WA-1:0] words[3];
    rst = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a = '0;
    data_b = '0;
    #12;
    check_eq("rst_pins_a", {ser_a, sclk_a, lclk_a, busy_a, done_a}, 0);
    check_eq("rst_ready_a", ready_a, 1);
    check_eq("rst_pins_b", {ser_b, sclk_b, lclk_b, busy_b, done_b}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(0, 16'h2A52);

    // Back-to-back with valid held.
    lc0 = lclk_cnt_a;
    wait_accept(0, 16'hAF7F, 1'b1, ok);
    wait_accept(0, 16'h0001, 1'b0, ok);
    wait_lclk_a(lc0 + 2);
    wait_idle(0);
    if (lat_a.size() >= lc0 + 2) begin
      check_eq("b2b_word0", lat_a[lc0], 16'hAF7F);
      check_eq("b2b_word1", lat_a[lc0+1], 16'h0001);
      check_eq("b2b_period", lclk_cyc_a[lc0+1] - lclk_cyc_a[lc0], GapA);
    end

`ifndef SHREG_TX_BUFFER_EN
    // valid_i while busy must be ignored.
    lc0 = lclk_cnt_a;
    wait_accept(0, 16'h5AC3, 1'b0, ok);
    repeat (10) @(posedge clk);
    @(negedge clk);
    data_a = 16'hFFFF;
    valid_a = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("ign_ready", ready_a, 0);
    valid_a = 1'b0;
    wait_idle(0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("ign_busy", busy_a, 0);
    check_eq("ign_lclk_cnt", lclk_cnt_a, lc0 + 1);
    check_eq("ign_word", out_a, 16'h5AC3);
`endif

    // Reset during the sclk-high phase of bit 5.
    lc0 = lclk_cnt_a;
    prev = out_a;
    wait_accept(0, 16'h1234, 1'b0, ok);
    repeat (22) @(posedge clk);
    #1;
    check_eq("pre_rst_sclk", {busy_a, sclk_a}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_pins", {ser_a, sclk_a, lclk_a, busy_a, done_a}, 0);
    check_eq("midrst_ready", ready_a, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (FrameA + 10) @(posedge clk);
    #1;
    check_eq("postrst_ready", ready_a, 1);
    check_eq("postrst_lclk", lclk_cnt_a, lc0);
    check_eq("postrst_out", out_a, prev);

    run_frame(1, 16'h00A5);

    // Three streamed words.
    words[0] = 16'h0001;
    words[1] = 16'h8000;
    words[2] = 16'hFFFF;
    lc0 = lclk_cnt_a;
    rl_max = 0;
    wait_accept(0, words[0], 1'b1, ok);
    wait_accept(0, words[1], 1'b1, ok);
    wait_accept(0, words[2], 1'b0, ok);
    wait_lclk_a(lc0 + 3);
    wait_idle(0);
    check_eq("stream_ready_low", rl_max <= int'(FrameA), 1);
    if (lat_a.size() >= lc0 + 3) begin
      for (int i = 0; i < 3; i++) check_eq("stream_word", lat_a[lc0+i], words[i]);
      for (int i = 0; i < 2; i++)
        check_eq("stream_period", lclk_cyc_a[lc0+i+1] - lclk_cyc_a[lc0+i], GapA);
    end

    for (int i = 0; i < 6; i++) begin
      w = WA'($urandom);
      run_frame(0, w);
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      w = WA'($urandom_range(0, 255));
      run_frame(1, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
